// File: rtl/seq_pkg.sv
// Shared types and constants for the accumulator-core execution sequencer.
package seq_pkg;

  // Sequencer FSM encoding, also visible on the state_dbg port.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    WB       = 2'd3
  } seq_state_t;

  // Sticky error codes reported on err.
  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_MEM_TMO   = 2'b11;

  // Number of occupied operand slots.
  function automatic logic [1:0] count_valids(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/operand_slots.sv
// Three-entry operand collector: pushes fill r0, r1, r2 in order; clear
// empties every slot at once and wins over a push in the same cycle.
module operand_slots
  import seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          clear,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [2:0]    valid,
  output logic [1:0]    count,
  output logic          full
);

  assign count = count_valids(valid);
  assign full  = &valid;

  // Slot storage: a push lands in the lowest-numbered empty slot.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r0    <= '0;
      r1    <= '0;
      r2    <= '0;
      valid <= 3'b000;
    end else if (push && !full) begin
      if (!valid[0]) begin
        r0       <= push_data;
        valid[0] <= 1'b1;
      end else if (!valid[1]) begin
        r1       <= push_data;
        valid[1] <= 1'b1;
      end else begin
        r2       <= push_data;
        valid[2] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/op_sequencer.sv
// Multi-cycle execution sequencer for the 8-bit accumulator core.
// Collects PUT operands, then walks each OP through EXEC, an optional
// MEM_WAIT and WB, retiring it with exactly one pc_adv or absjump_en pulse.
//
// Handshake: the memory side holds mem_rd_en/mem_wr_en high for every
// MEM_WAIT cycle; the access completes on the first rising edge where
// mem_ready is sampled high together with the enable. Instruction inputs
// (putEn/opEn/value/op_nargs) are only looked at in IDLE; the OP flags must
// stay stable until busy drops.
module op_sequencer
  import seq_pkg::*;
#(
  parameter int DW      = 8,
  parameter int PCW     = 12,
  parameter int MEM_TMO = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           putEn,
  input  logic           opEn,
  input  logic [DW-1:0]  value,
  input  logic [1:0]     op_nargs,
  input  logic           regWriteFlag,
  input  logic           memWriteFlag,
  input  logic           memToRegFlag,
  input  logic           branchFlag,
  input  logic           aluBranchFlag,
  input  logic           mem_ready,
  input  logic [PCW-1:0] prog_ctr,
  output logic [DW-1:0]  r0,
  output logic [DW-1:0]  r1,
  output logic [DW-1:0]  r2,
  output logic           r0_valid,
  output logic           r1_valid,
  output logic           r2_valid,
  output logic           rf_wr_en,
  output logic           mem_wr_en,
  output logic           mem_rd_en,
  output logic           pc_adv,
  output logic           absjump_en,
  output logic [PCW-1:0] target,
  output logic           busy,
  output logic [1:0]     err,
  output logic [1:0]     state_dbg
);

  seq_state_t     state_q, state_d;
  logic [3:0]     tmo_cnt_q, tmo_cnt_d;
  logic           cond_q, cond_d;
  logic           pc_adv_q, pc_adv_d;
  logic [1:0]     err_q, err_d;
  logic [PCW-1:0] target_q, target_d;

  logic           slot_push;
  logic           slot_clear;
  logic [2:0]     slot_valid;
  logic [1:0]     slot_count;
  logic           slot_full;
  logic           mem_op;
  logic           take_in_wb;
  logic [PCW-1:0] jump_sum;

  operand_slots #(.DW(DW)) u_slots (
    .clk       (clk),
    .reset     (reset),
    .push      (slot_push),
    .clear     (slot_clear),
    .push_data (value),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .valid     (slot_valid),
    .count     (slot_count),
    .full      (slot_full)
  );

  assign mem_op = memToRegFlag | memWriteFlag;

  // Branch target: PC plus sign-extended r0, wrapping at PCW bits.
  assign jump_sum = prog_ctr + {{(PCW-DW){r0[DW-1]}}, r0};

  // Next-state, slot control and error logic.
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    cond_d     = cond_q;
    pc_adv_d   = 1'b0;
    err_d      = err_q;
    target_d   = target_q;
    slot_push  = 1'b0;
    slot_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (opEn) begin
          // A PUT arriving together with an OP is a control conflict.
          if (putEn) err_d = ERR_OVERFLOW;
          if (slot_count < op_nargs) begin
            err_d      = ERR_UNDERFLOW;
            slot_clear = 1'b1;
            pc_adv_d   = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end else if (putEn) begin
          pc_adv_d = 1'b1;
          if (slot_full) err_d = ERR_OVERFLOW;
          else           slot_push = 1'b1;
        end
      end
      EXEC: begin
        cond_d    = aluBranchFlag;
        tmo_cnt_d = 4'd0;
        if (mem_op) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = WB;
          if (branchFlag && aluBranchFlag) target_d = jump_sum;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = WB;
          if (branchFlag && cond_q) target_d = jump_sum;
        end else if (tmo_cnt_q == 4'(MEM_TMO - 1)) begin
          err_d      = ERR_MEM_TMO;
          slot_clear = 1'b1;
          pc_adv_d   = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
      end
      WB: begin
        slot_clear = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tmo_cnt_q <= 4'd0;
      cond_q    <= 1'b0;
      pc_adv_q  <= 1'b0;
      err_q     <= ERR_NONE;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      cond_q    <= cond_d;
      pc_adv_q  <= pc_adv_d;
      err_q     <= err_d;
      target_q  <= target_d;
    end
  end

  // WB retires either by jump or by PC increment, never both.
  assign take_in_wb = (state_q == WB) && branchFlag && cond_q;

  assign rf_wr_en   = (state_q == WB) && regWriteFlag;
  assign absjump_en = take_in_wb;
  assign pc_adv     = pc_adv_q | ((state_q == WB) && !take_in_wb);
  assign mem_rd_en  = (state_q == MEM_WAIT) && memToRegFlag;
  assign mem_wr_en  = (state_q == MEM_WAIT) && memWriteFlag;
  assign target     = target_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign state_dbg  = state_q;
  assign r0_valid   = slot_valid[0];
  assign r1_valid   = slot_valid[1];
  assign r2_valid   = slot_valid[2];

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: every retire strobe is matched against
// an expected-event queue filled by the driver, plus direct state checks.
module tb_op_sequencer;

  localparam int DW  = 8;
  localparam int PCW = 12;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           putEn = 0, opEn = 0;
  logic [DW-1:0]  value = 0;
  logic [1:0]     op_nargs = 0;
  logic           regWriteFlag = 0, memWriteFlag = 0, memToRegFlag = 0;
  logic           branchFlag = 0, aluBranchFlag = 0, mem_ready = 0;
  logic [PCW-1:0] prog_ctr = 0;
  logic [DW-1:0]  r0, r1, r2;
  logic           r0_valid, r1_valid, r2_valid;
  logic           rf_wr_en, mem_wr_en, mem_rd_en, pc_adv, absjump_en, busy;
  logic [PCW-1:0] target;
  logic [1:0]     err, state_dbg;

  op_sequencer #(.DW(DW), .PCW(PCW), .MEM_TMO(15)) dut (
    .clk(clk), .reset(reset), .putEn(putEn), .opEn(opEn), .value(value),
    .op_nargs(op_nargs), .regWriteFlag(regWriteFlag), .memWriteFlag(memWriteFlag),
    .memToRegFlag(memToRegFlag), .branchFlag(branchFlag), .aluBranchFlag(aluBranchFlag),
    .mem_ready(mem_ready), .prog_ctr(prog_ctr), .r0(r0), .r1(r1), .r2(r2),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r2_valid(r2_valid),
    .rf_wr_en(rf_wr_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .pc_adv(pc_adv), .absjump_en(absjump_en), .target(target), .busy(busy),
    .err(err), .state_dbg(state_dbg)
  );

  // Scoreboard: event = {pc_adv, absjump_en, rf_wr_en, err, target-if-jump}
  localparam int EW = 5 + PCW;
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int rd_total = 0;
  int wr_total = 0;
  int mem_lat = 0;
  int mem_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_ev(input logic pa, input logic aj, input logic rf,
                                          input logic [1:0] e, input logic [PCW-1:0] t);
    return {pa, aj, rf, e, t};
  endfunction

  // Monitor: pops one expected event per retire-strobe cycle.
  always @(negedge clk) begin
    logic [EW-1:0] act, ev;
    if (!reset) begin
      if (mem_rd_en) rd_total++;
      if (mem_wr_en) wr_total++;
      if (pc_adv || absjump_en || rf_wr_en) begin
        act = {pc_adv, absjump_en, rf_wr_en, err, (absjump_en ? target : {PCW{1'b0}})};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: actual=0x%0h expected=none", act);
        end else begin
          ev = exp_q.pop_front();
          check("retire_event", 32'(act), 32'(ev));
        end
      end
    end
  end

  // Memory responder: raises mem_ready in the mem_lat-th enabled cycle (0 = never).
  always @(posedge clk) begin
    #1;
    if (mem_rd_en || mem_wr_en) begin
      mem_cnt++;
      mem_ready = (mem_cnt == mem_lat);
    end else begin
      mem_cnt = 0;
      mem_ready = 0;
    end
  end

  // Driver tasks
  task automatic do_reset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic do_put(input logic [DW-1:0] v, input logic [1:0] exp_err);
    exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, exp_err, '0));
    value = v; putEn = 1;
    @(posedge clk); #1 putEn = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [1:0] nargs, input logic rw, input logic mw, input logic mr,
                       input logic br, input logic cond, input int lat, input logic with_put,
                       input logic [EW-1:0] ev, input int exp_busy, input string name);
    int bc;
    op_nargs = nargs; regWriteFlag = rw; memWriteFlag = mw; memToRegFlag = mr;
    branchFlag = br; aluBranchFlag = cond; mem_lat = lat;
    exp_q.push_back(ev);
    opEn = 1; putEn = with_put;
    @(posedge clk); #1 opEn = 0; putEn = 0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      bc++;
      @(posedge clk); #1;
    end
    check({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    regWriteFlag = 0; memWriteFlag = 0; memToRegFlag = 0; branchFlag = 0; aluBranchFlag = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int rd0, wr0;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_valids", 32'({r0_valid, r1_valid, r2_valid}), 32'd0);
    check("rst_slots", {8'h0, r0, r1, r2}, 32'h0);
    check("rst_strobes", 32'({pc_adv, absjump_en, rf_wr_en, mem_rd_en, mem_wr_en, busy}), 32'd0);
    check("rst_err_target", 32'({err, target}), 32'd0);

    // Three PUTs then ADD
    do_put(8'h05, 2'b00);
    do_put(8'h03, 2'b00);
    do_put(8'h02, 2'b00);
    check("put3_valids", 32'({r0_valid, r1_valid, r2_valid}), 32'b111);
    check("put3_slots", {8'h0, r0, r1, r2}, 32'h00050302);
    do_op(2'd3, 1, 0, 0, 0, 0, 0, 0, mk_ev(1, 0, 1, 2'b00, '0), 2, "add");
    check("add_cleared", 32'({r0_valid, r1_valid, r2_valid, r0, r1, r2}), 32'd0);

    // Fourth PUT overflows
    do_put(8'h01, 2'b00);
    do_put(8'h02, 2'b00);
    do_put(8'h03, 2'b00);
    do_put(8'h09, 2'b10);
    check("ovf_slots", {8'h0, r0, r1, r2}, 32'h00010203);
    check("ovf_err", 32'(err), 32'b10);
    do_reset();

    // Underflow: nargs=2 with one operand
    rd0 = rd_total; wr0 = wr_total;
    do_put(8'h07, 2'b00);
    do_op(2'd2, 1, 0, 0, 0, 0, 0, 0, mk_ev(1, 0, 0, 2'b01, '0), 0, "underflow");
    check("uf_cleared", 32'({r0_valid, r0}), 32'd0);
    check("uf_err", 32'(err), 32'b01);
    check("uf_mem_cycles", 32'((rd_total - rd0) + (wr_total - wr0)), 32'd0);
    do_reset();

    // Load, mem_ready in the 4th wait cycle
    rd0 = rd_total;
    do_put(8'h11, 2'b00);
    do_op(2'd1, 1, 0, 1, 0, 0, 4, 0, mk_ev(1, 0, 1, 2'b00, '0), 6, "load");
    check("load_rd_cycles", 32'(rd_total - rd0), 32'd4);

    // Load that never completes
    rd0 = rd_total;
    do_put(8'h22, 2'b00);
    do_op(2'd1, 1, 0, 1, 0, 0, 0, 0, mk_ev(1, 0, 0, 2'b11, '0), 16, "tmo");
    check("tmo_rd_cycles", 32'(rd_total - rd0), 32'd15);
    check("tmo_err", 32'(err), 32'b11);
    check("tmo_cleared", 32'({r0_valid, r0}), 32'd0);
    do_reset();

    // Taken branch: 0x001 + sext(0xFE) = 0xFFF
    prog_ctr = 12'h001;
    do_put(8'hFE, 2'b00);
    do_op(2'd1, 0, 0, 0, 1, 1, 0, 0, mk_ev(0, 1, 0, 2'b00, 12'hFFF), 2, "br_taken");
    check("br_target_reg", 32'(target), 32'hFFF);

    // Not-taken branch
    prog_ctr = 12'h010;
    do_put(8'h04, 2'b00);
    do_op(2'd1, 0, 0, 0, 1, 0, 0, 0, mk_ev(1, 0, 0, 2'b00, '0), 2, "br_not_taken");

    // Taken branch with positive offset: 0x7F0 + 0x7F = 0x86F
    prog_ctr = 12'h7F0;
    do_put(8'h7F, 2'b00);
    do_op(2'd1, 0, 0, 0, 1, 1, 0, 0, mk_ev(0, 1, 0, 2'b00, 12'h86F), 2, "br_pos");

    // Store, 2 wait cycles
    wr0 = wr_total; rd0 = rd_total;
    do_put(8'h33, 2'b00);
    do_put(8'h44, 2'b00);
    do_op(2'd2, 0, 1, 0, 0, 0, 2, 0, mk_ev(1, 0, 0, 2'b00, '0), 4, "store");
    check("store_wr_cycles", 32'(wr_total - wr0), 32'd2);
    check("store_rd_cycles", 32'(rd_total - rd0), 32'd0);

    // PUT and OP together: conflict flagged, OP still retires
    do_put(8'h55, 2'b00);
    do_op(2'd1, 1, 0, 0, 0, 0, 0, 1, mk_ev(1, 0, 1, 2'b10, '0), 2, "conflict");
    check("conflict_err", 32'(err), 32'b10);
    check("conflict_no_push", 32'({r0_valid, r0}), 32'd0);
    do_reset();

    // Reset while in MEM_WAIT
    do_put(8'h01, 2'b00);
    op_nargs = 2'd1; memToRegFlag = 1; regWriteFlag = 1; mem_lat = 0;
    opEn = 1;
    @(posedge clk); #1 opEn = 0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_state_memwait", 32'(state_dbg), 32'd2);
    reset = 1;
    @(posedge clk); #1;
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_outputs", 32'({pc_adv, absjump_en, rf_wr_en, mem_rd_en, mem_wr_en, busy}), 32'd0);
    check("mid_rst_slots", 32'({r0_valid, r1_valid, r2_valid, r0}), 32'd0);
    check("mid_rst_err", 32'({err, target}), 32'd0);
    memToRegFlag = 0; regWriteFlag = 0;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
